// File: rtl/mnist_window_gen.sv
// rtl/mnist_window_gen.sv - 28x28 frame buffer that issues every 5x5 stride-1 window to simpleCNN
module mnist_window_gen #(
    parameter int IMG_W = 28,
    parameter int K     = 5
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       PIX_VALID,
    input  logic [7:0]                 PIX_DATA,
    output logic                       PIX_READY,
    output logic                       START,
    input  logic                       ACCEPT,
    output logic [$clog2(IMG_W)-1:0]   X,
    output logic [$clog2(IMG_W)-1:0]   Y,
    output logic [K*K*8-1:0]           IMGIN,
    output logic                       FRAME_DONE
);
    localparam int NPIX     = IMG_W * IMG_W;
    localparam int AW       = $clog2(NPIX);
    localparam int PW       = $clog2(IMG_W);
    localparam int JW       = $clog2(K);
    localparam int BW       = $clog2(K * K);
    localparam int LAST_POS = IMG_W - K;

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_GATHER = 2'd1;
    localparam logic [1:0] S_OFFER  = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] load_cnt;
    logic [JW-1:0] i;
    logic [JW-1:0] j;
    logic [7:0]    mem [NPIX];
    logic [AW-1:0] row_base;
    logic [AW-1:0] rd_addr;
    logic [BW-1:0] byte_idx;
    logic          pix_fire;

    assign pix_fire = (state == S_LOAD) && PIX_VALID && PIX_READY;

    // Row base times a constant plus a column offset keeps the address free of any divider.
    assign row_base = (AW'(X) + AW'(i)) * AW'(IMG_W);
    assign rd_addr  = row_base + AW'(Y) + AW'(j);
    assign byte_idx = BW'(i) * BW'(K) + BW'(j);

    // Buffer has no reset; it is fully rewritten by every load before it is read.
    always_ff @(posedge CLK) begin
        if (pix_fire) begin
            mem[load_cnt] <= PIX_DATA;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= S_LOAD;
            load_cnt   <= '0;
            X          <= '0;
            Y          <= '0;
            i          <= '0;
            j          <= '0;
            IMGIN      <= '0;
            START      <= 1'b0;
            FRAME_DONE <= 1'b0;
            PIX_READY  <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                S_LOAD: begin
                    PIX_READY <= 1'b1;
                    if (pix_fire) begin
                        if (load_cnt == AW'(NPIX - 1)) begin
                            state     <= S_GATHER;
                            PIX_READY <= 1'b0;
                            load_cnt  <= '0;
                            X         <= '0;
                            Y         <= '0;
                            i         <= '0;
                            j         <= '0;
                        end else begin
                            load_cnt <= load_cnt + AW'(1);
                        end
                    end
                end
                S_GATHER: begin
                    IMGIN[byte_idx*8 +: 8] <= mem[rd_addr];
                    if (j == JW'(K - 1)) begin
                        j <= '0;
                        if (i == JW'(K - 1)) begin
                            i     <= '0;
                            START <= 1'b1;
                            state <= S_OFFER;
                        end else begin
                            i <= i + JW'(1);
                        end
                    end else begin
                        j <= j + JW'(1);
                    end
                end
                S_OFFER: begin
                    if (ACCEPT) begin
                        START <= 1'b0;
                        if (Y == PW'(LAST_POS)) begin
                            Y <= '0;
                            if (X == PW'(LAST_POS)) begin
                                X          <= '0;
                                FRAME_DONE <= 1'b1;
                                PIX_READY  <= 1'b1;
                                load_cnt   <= '0;
                                state      <= S_LOAD;
                            end else begin
                                X     <= X + PW'(1);
                                state <= S_GATHER;
                            end
                        end else begin
                            Y     <= Y + PW'(1);
                            state <= S_GATHER;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: doc/mnist_window_gen.md
# mnist_window_gen

Upstream feeder for `simpleCNN`. Accepts one 28x28 8-bit MNIST image as a raster pixel stream into an internal frame buffer, then issues all 576 overlapping 5x5 windows (stride 1) to the CNN on its `START`/`X`/`Y`/`IMGIN` interface, one window per handshake. It pulses `FRAME_DONE` after the last window and then returns to loading the next image.

## Interface
- `IMG_W`, 28: image width and height in pixels (square image).
- `K`, 5: window side length; `IMGIN` width is K*K*8.
- `CLK`  in  1: single clock, rising edge.
- `nRST`  in  1: asynchronous reset, active-low.
- `PIX_VALID`  in  1: `PIX_DATA` is valid.
- `PIX_DATA`  in  8: pixel value, raster order (row 0 col 0 first).
- `PIX_READY`  out  1: block accepts a pixel; a transfer happens on a rising edge with `PIX_VALID & PIX_READY`.
- `START`  out  1: window valid to CNN; held until accepted.
- `ACCEPT`  in  1: CNN takes the window; a transfer happens on a rising edge with `START & ACCEPT`.
- `X`  out  5: window top row, 0..23.
- `Y`  out  5: window left column, 0..23.
- `IMGIN`  out  200: window; byte `(i*5+j)` at `IMGIN[(i*5+j)*8 +: 8]` = pixel(row X+i, col Y+j).
- `FRAME_DONE`  out  1: one-cycle pulse after the 576th window is accepted.

## Operation
- Frame buffer: 784 x 8 register array, combinational read, written only in LOAD.
- States: LOAD, GATHER, OFFER.
- LOAD: `PIX_READY`=1. Each accepted pixel is written to `mem[load_cnt]` and `load_cnt` increments (0..783). The edge that accepts pixel 783 moves the block to GATHER with X=0, Y=0, and `PIX_READY`<=0.
- GATHER: 25 cycles, with sub-counters i (row) and j (col) 0..4 and j fastest. Each edge writes `IMGIN` byte (i*5+j) = `mem[(X+i)*28 + (Y+j)]`. The address is formed from a row base plus a column, with no divider. The edge that writes byte 24 sets `START`<=1 and moves to OFFER.
- OFFER: `START`=1, and `IMGIN`, `X`, `Y` are held stable. On an edge with `ACCEPT`=1:
  - `START`<=0.
  - Advance Y. When Y wraps 23->0, advance X.
  - If the accepted window is not (23,23), go to GATHER.
  - If the accepted window is (23,23): `FRAME_DONE`<=1 for one cycle, X=Y=0, `load_cnt`=0, `PIX_READY`<=1, go to LOAD.
- Window order: Y fastest, then X. That gives 24*24 = 576 windows per frame.
- `PIX_VALID` outside LOAD is ignored, and no buffer write occurs.
- `ACCEPT` outside OFFER is ignored.
- `X`/`Y`/`IMGIN` are meaningful only while `START`=1. `X`/`Y` change on the accept edge, while `IMGIN` changes during GATHER.
- Arithmetic: `load_cnt` 10 bits; address (X+i)*28+(Y+j) ≤ 783, 10 bits; X, Y, i, j unsigned.

## Timing
- Reset (`nRST`=0, async):
  - State LOAD, `load_cnt`=0, X=0, Y=0, i=j=0.
  - Outputs: `IMGIN`=0, `START`=0, `FRAME_DONE`=0, `PIX_READY`=0.
  - `PIX_READY` rises at the first rising edge after `nRST` deasserts.
  - Buffer contents are not reset.
- Load: 784 transfers at minimum; one pixel per cycle when `PIX_VALID` is held high.
- First window: `START` rises at the 25th edge after the edge accepting pixel 783.
- Window throughput: with `ACCEPT` tied high, one window per 26 cycles (25 GATHER + 1 OFFER). A frame takes 576*26 = 14976 cycles after load.
- Backpressure: `START`, `IMGIN`, `X`, `Y` are stable for any number of cycles while `ACCEPT`=0.
- `FRAME_DONE` is high for exactly the cycle after the final accept edge, and `PIX_READY` is high in that same cycle. A pixel may be accepted on the very next edge.
- Reset mid-operation (any state): immediate return to reset values. A partially loaded image or pending window is discarded, and a fresh 784-pixel load is required.

## Test plan
- Reset: assert `nRST`=0 mid-GATHER.
  - Required: `START`=0, `IMGIN`=0, X=Y=0, `PIX_READY`=0 immediately.
  - Required: `PIX_READY`=1 one edge after release.
- Ramp image (pixel p = p mod 256), `ACCEPT`=1.
  - Window (0,0): `IMGIN` byte k = (k/5)*28 + k%5, i.e. byte 0=0x00, byte 4=0x04, byte 5=0x1C, byte 24=0x74.
  - `START` rises 25 edges after the last pixel.
- Same image, window (23,23): byte 0 = 667 mod 256 = 0x9B, byte 24 = 783 mod 256 = 0x0F. Exactly 576 accepts, then one `FRAME_DONE` pulse and `PIX_READY`=1.
- Backpressure: hold `ACCEPT`=0 for 10 cycles on window (3,7).
  - Required: `START`, `IMGIN`, X=3, Y=7 stable throughout.
  - Required: next window (3,8) on `START`'s next rise; (3,23) is followed by (4,0).
- Protocol: toggle `PIX_VALID` during GATHER/OFFER with junk data, and pulse `ACCEPT` during GATHER.
  - Required: no buffer corruption (window values match the ramp) and no spurious advance of X/Y.
- Back-to-back frames: second image (all 0xFF) streamed immediately after `FRAME_DONE` with gaps in `PIX_VALID`.
  - Required: all windows `IMGIN` = all ones, and a second `FRAME_DONE`.
